// File: rtl/sha_mem_pkg.sv
// ----------------------------------------------------------------------------
// sha_mem_pkg
// Shared types and constants for the SHA hash-core memory arbiter.
//   arb_state_t  : arbiter FSM state (IDLE, OWN)
//   SHA_ADDR_W   : memory address width
//   SHA_DATA_W   : memory data width
//   SHA_MAX_REQ  : largest supported number of requesters
// ----------------------------------------------------------------------------
package sha_mem_pkg;

  localparam int SHA_ADDR_W  = 16;
  localparam int SHA_DATA_W  = 32;
  localparam int SHA_MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. The winner is the first set
// bit of req_i at or after ptr_i, wrapping from N-1 back to 0.
// Ports:
//   req_i    [N-1:0]     request vector
//   ptr_i    [PTR_W-1:0] highest-priority index this cycle
//   any_o                at least one request is set
//   winner_o [N-1:0]     one-hot winner (all zero when any_o is low)
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             any_o,
  output logic [N-1:0]     winner_o
);

  logic [PTR_W-1:0] idx;

  // Scan from the lowest priority offset up to offset 0 so the last hit,
  // which is the one closest to the pointer, overrides earlier ones.
  always_comb begin
    any_o    = |req_i;
    winner_o = '0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        winner_o      = '0;
        winner_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha_mem_arbiter.sv
// ----------------------------------------------------------------------------
// sha_mem_arbiter
// Round-robin arbiter that lets NUM_REQ SHA hash cores share one synchronous
// memory port. A core raises req and holds it for the whole transaction; once
// granted, its req_we/req_addr/req_wdata drive the memory directly. Dropping
// req releases the port, and every handover passes through one IDLE cycle.
//
// Request/grant handshake: req is a level held by the core for as long as it
// wants the port; gnt is registered and one-hot. A core's command reaches the
// memory only in cycles where it owns the port and its req is still high, so
// a command offered while gnt is low is simply deferred, never lost.
//
// Optional feature macro: SHA_ARB_BURST_LIMIT_EN
//   When defined, an owner that has held the port for MAX_BURST cycles while
//   another core is waiting is revoked and must re-arbitrate.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   req              per-core request level
//   req_we/addr/wdata per-core memory command
//   gnt              registered one-hot grant
//   rd_data          memory read data broadcast to all cores
//   rd_valid         one-hot marker of which core rd_data belongs to
//   mem_clk          memory clock (same as clk)
//   mem_we/addr/write_data  memory command
//   mem_read_data    memory read data, one cycle after the address
//   dbg_state_o      current FSM state
//   dbg_rr_ptr_o     current round-robin pointer
// ----------------------------------------------------------------------------
module sha_mem_arbiter
  import sha_mem_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   req_we,
  input  logic [NUM_REQ-1:0][SHA_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][SHA_DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [SHA_DATA_W-1:0]                rd_data,
  output logic [NUM_REQ-1:0]                   rd_valid,
  output logic                                 mem_clk,
  output logic                                 mem_we,
  output logic [SHA_ADDR_W-1:0]                mem_addr,
  output logic [SHA_DATA_W-1:0]                mem_write_data,
  input  logic [SHA_DATA_W-1:0]                mem_read_data,
  output arb_state_t                           dbg_state_o,
  output logic [$clog2(NUM_REQ)-1:0]           dbg_rr_ptr_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // The burst counter is 6 bits wide, so MAX_BURST must fit in it.
  if (NUM_REQ < 2 || NUM_REQ > SHA_MAX_REQ || MAX_BURST < 1 || MAX_BURST > 64) begin : g_param_check
    $error("sha_mem_arbiter: NUM_REQ must be 2..8 and MAX_BURST 1..64");
  end

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       owner_next;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     rd_valid_q, rd_valid_d;
  logic [SHA_ADDR_W-1:0]  addr_q, addr_d;
  logic [SHA_DATA_W-1:0]  wdata_q, wdata_d;

  logic                   pick_any;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   owner_req;
  logic                   revoke;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_onehot)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_onehot[k]) pick_idx = IDX_W'(k);
    end
  end

  assign owner_req  = req[owner_q];
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef SHA_ARB_BURST_LIMIT_EN
  logic [5:0] burst_q, burst_d;
  logic       others_req;

  // gnt_q is the owner's one-hot bit while in OWN, so masking it leaves
  // only the cores that are waiting.
  assign others_req = |(req & ~gnt_q);
  assign revoke     = (state_q == OWN) && (burst_q == 6'(MAX_BURST - 1)) && others_req;

  // Held at zero in IDLE so every new ownership starts from zero. It stops
  // at the limit so a late-arriving waiter is served as soon as it shows up
  // rather than after the counter wraps.
  always_comb begin
    burst_d = '0;
    if (state_q == OWN) begin
      burst_d = (burst_q == 6'(MAX_BURST - 1)) ? burst_q : burst_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign revoke = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = OWN;
          owner_d = pick_idx;
          gnt_d   = pick_onehot;
        end
      end
      OWN: begin
        if (!owner_req || revoke) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = owner_next;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Memory command mux. Address and data fall back to the last value driven
  // so the memory bus stays quiet between owners. The owner's write is
  // suppressed in its release cycle and in any reset cycle.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = addr_q;
    mem_write_data = wdata_q;
    rd_valid_d     = '0;
    if (state_q == OWN) begin
      mem_addr       = req_addr[owner_q];
      mem_write_data = req_wdata[owner_q];
      mem_we         = owner_req & req_we[owner_q] & ~reset;
      if (owner_req && !req_we[owner_q]) rd_valid_d[owner_q] = 1'b1;
    end
    addr_d  = mem_addr;
    wdata_d = mem_write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign gnt          = gnt_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = mem_read_data;
  assign mem_clk      = clk;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sha_mem_arbiter
// Directed bench for sha_mem_arbiter with four requesters. Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
// A small memory model returns {16'hA5A5, addr} one cycle after the address
// and records every write it sees.
// ----------------------------------------------------------------------------
module tb_sha_mem_arbiter;
  import sha_mem_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N-1:0]         req_we;
  logic [N-1:0][15:0]   req_addr;
  logic [N-1:0][31:0]   req_wdata;
  logic [N-1:0]         gnt;
  logic [31:0]          rd_data;
  logic [N-1:0]         rd_valid;
  logic                 mem_clk;
  logic                 mem_we;
  logic [15:0]          mem_addr;
  logic [31:0]          mem_write_data;
  logic [31:0]          mem_read_data;
  arb_state_t           dbg_state;
  logic [1:0]           dbg_rr_ptr;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  int          wr_count = 0;
  logic [15:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  sha_mem_arbiter #(.NUM_REQ(N), .MAX_BURST(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .gnt            (gnt),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .dbg_state_o    (dbg_state),
    .dbg_rr_ptr_o   (dbg_rr_ptr)
  );

  // Clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_read_data <= {16'hA5A5, mem_addr};
    if (mem_we === 1'b1) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_write_data;
    end
  end

  // gnt must be one-hot or zero in every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(gnt) || $isunknown(gnt)) begin
        errors++;
        $display("FAIL gnt_onehot0: got %b, need one-hot or zero", gnt);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '1; req_we = '1;
    req_addr = {N{16'hFFFF}}; req_wdata = {N{32'hFFFF_FFFF}};
    tick(); tick(); sample();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL rst_rd_valid: got %b want 0000", rd_valid); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_write_data); end
    checks++; if (dbg_rr_ptr !== 2'd0) begin errors++; $display("FAIL rst_rr_ptr: got %0d want 0", dbg_rr_ptr); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    reset = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    tick(); req = 4'b0001; req_we = 4'b0000; req_addr[0] = 16'h0010; sample();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rd_gnt_pre: got %b want 0000", gnt); end
    tick(); sample();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rd_gnt: got %b want 0001", gnt); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_addr: got %h want 0010", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", mem_we); end
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL rd_valid_c1: got %b want 0000", rd_valid); end
    tick(); sample();
    checks++; if (rd_valid !== 4'b0001) begin errors++; $display("FAIL rd_valid_c2: got %b want 0001", rd_valid); end
    checks++; if (rd_data !== 32'hA5A5_0010) begin errors++; $display("FAIL rd_data: got %h want a5a50010", rd_data); end
    tick(); sample();
    checks++; if (rd_valid !== 4'b0001) begin errors++; $display("FAIL rd_valid_c3: got %b want 0001", rd_valid); end
    tick(); req = 4'b0000; sample();
    checks++; if (rd_valid !== 4'b0001) begin errors++; $display("FAIL rd_valid_c4: got %b want 0001", rd_valid); end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rd_gnt_rel: got %b want 0001", gnt); end
    tick(); sample();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rd_gnt_idle: got %b want 0000", gnt); end
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL rd_valid_idle: got %b want 0000", rd_valid); end
    checks++; if (dbg_rr_ptr !== 2'd1) begin errors++; $display("FAIL rd_rr_ptr: got %0d want 1", dbg_rr_ptr); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_addr_hold: got %h want 0010", mem_addr); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rd_state_idle: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_all_request();
    logic [N-1:0] exp_gnt;
    logic [1:0]   exp_ptr;
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = 16'h0100 + 16'(i);
      req_wdata[i] = 32'hC0DE_0000 + 32'(i);
    end
    req_we = 4'b1111; req = 4'b1111; sample();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL all_gnt_pre: got %b want 0000", gnt); end
    for (int i = 0; i < N; i++) begin
      exp_gnt = 4'b0001 << i;
      exp_ptr = 2'((i + 1) % N);
      tick(); sample();
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL all_gnt_%0d: got %b want %b", i, gnt, exp_gnt); end
      checks++; if (mem_we !== 1'b1 || mem_addr !== (16'h0100 + 16'(i))) begin errors++; $display("FAIL all_wr_%0d: got we=%b addr=%h want we=1 addr=%h", i, mem_we, mem_addr, 16'h0100 + 16'(i)); end
      tick(); sample();
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL all_gnt2_%0d: got %b want %b", i, gnt, exp_gnt); end
      tick(); req[i] = 1'b0; sample();
      checks++; if (gnt !== exp_gnt || mem_we !== 1'b0) begin errors++; $display("FAIL all_rel_%0d: got gnt=%b we=%b want gnt=%b we=0", i, gnt, mem_we, exp_gnt); end
      tick(); sample();
      checks++; if (gnt !== 4'b0000 || mem_we !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL all_idle_%0d: got gnt=%b we=%b st=%0d want 0000/0/IDLE", i, gnt, mem_we, dbg_state); end
      checks++; if (dbg_rr_ptr !== exp_ptr) begin errors++; $display("FAIL all_ptr_%0d: got %0d want %0d", i, dbg_rr_ptr, exp_ptr); end
    end
    req_we = '0;
  endtask

  task automatic test_wrap();
    tick(); req = 4'b0100; req_we = 4'b0000; sample();
    tick(); sample();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_gnt2: got %b want 0100", gnt); end
    tick(); req = 4'b0000; sample();
    tick(); req = 4'b1001; sample();
    checks++; if (dbg_rr_ptr !== 2'd3) begin errors++; $display("FAIL wrap_ptr3: got %0d want 3", dbg_rr_ptr); end
    tick(); sample();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3: got %b want 1000", gnt); end
    tick(); req = 4'b0001; sample();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3_rel: got %b want 1000", gnt); end
    tick(); sample();
    checks++; if (gnt !== 4'b0000 || dbg_rr_ptr !== 2'd0) begin errors++; $display("FAIL wrap_idle: got gnt=%b ptr=%0d want 0000/0", gnt, dbg_rr_ptr); end
    tick(); sample();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b want 0001", gnt); end
    tick(); req = 4'b0000; sample();
    tick(); sample();
    checks++; if (dbg_rr_ptr !== 2'd1 || dbg_state !== IDLE) begin errors++; $display("FAIL wrap_end: got ptr=%0d st=%0d want 1/IDLE", dbg_rr_ptr, dbg_state); end
  endtask

  task automatic test_isolation();
    int base;
    tick(); base = wr_count;
    req_we = 4'b0110;
    req_addr[1] = 16'h0020; req_wdata[1] = 32'hDEAD_BEEF;
    req_addr[2] = 16'h0BAD; req_wdata[2] = 32'h1234_5678;
    req = 4'b0110; sample();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL iso_we_idle: got %b want 0", mem_we); end
    tick(); sample();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL iso_gnt1: got %b want 0010", gnt); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_write_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL iso_cmd1: got we=%b addr=%h data=%h want 1/0020/deadbeef", mem_we, mem_addr, mem_write_data); end
    tick(); req[1] = 1'b0; req_we[1] = 1'b0; sample();
    checks++; if (mem_we !== 1'b0 || mem_addr !== 16'h0020) begin errors++; $display("FAIL iso_rel: got we=%b addr=%h want 0/0020", mem_we, mem_addr); end
    tick(); sample();
    checks++; if (gnt !== 4'b0000 || mem_we !== 1'b0) begin errors++; $display("FAIL iso_idle: got gnt=%b we=%b want 0000/0", gnt, mem_we); end
    checks++; if (wr_count - base !== 1 || last_wr_addr !== 16'h0020 || last_wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL iso_mem1: got n=%0d addr=%h data=%h want 1/0020/deadbeef", wr_count - base, last_wr_addr, last_wr_data); end
    tick(); sample();
    checks++; if (gnt !== 4'b0100 || mem_addr !== 16'h0BAD || mem_we !== 1'b1) begin errors++; $display("FAIL iso_gnt2: got gnt=%b addr=%h we=%b want 0100/0bad/1", gnt, mem_addr, mem_we); end
    tick(); req = 4'b0000; req_we = 4'b0000; sample();
    tick(); sample();
    checks++; if (wr_count - base !== 2 || last_wr_addr !== 16'h0BAD || last_wr_data !== 32'h1234_5678) begin errors++; $display("FAIL iso_mem2: got n=%0d addr=%h data=%h want 2/0bad/12345678", wr_count - base, last_wr_addr, last_wr_data); end
  endtask

  task automatic test_reset_mid();
    int base;
    tick(); req = 4'b0001; req_we = 4'b0000; req_addr[0] = 16'h0044; sample();
    tick(); sample();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_gnt: got %b want 0001", gnt); end
    tick(); reset = 1'b1; sample();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_we_rd: got %b want 0", mem_we); end
    tick(); reset = 1'b0; req = 4'b0000; sample();
    checks++; if (gnt !== 4'b0000 || rd_valid !== 4'b0000) begin errors++; $display("FAIL rm_after: got gnt=%b rdv=%b want 0000/0000", gnt, rd_valid); end
    checks++; if (mem_we !== 1'b0 || dbg_rr_ptr !== 2'd0 || dbg_state !== IDLE || mem_addr !== 16'h0000) begin errors++; $display("FAIL rm_state: got we=%b ptr=%0d st=%0d addr=%h want 0/0/IDLE/0000", mem_we, dbg_rr_ptr, dbg_state, mem_addr); end
    // Owner writing when reset arrives
    tick(); req = 4'b0001; req_we = 4'b0001; req_wdata[0] = 32'h0BAD_F00D; sample();
    tick(); sample();
    checks++; if (gnt !== 4'b0001 || mem_we !== 1'b1) begin errors++; $display("FAIL rm_wr_own: got gnt=%b we=%b want 0001/1", gnt, mem_we); end
    tick(); reset = 1'b1; sample(); base = wr_count;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_we_wr: got %b want 0", mem_we); end
    tick(); reset = 1'b0; req = 4'b0000; req_we = 4'b0000; sample();
    checks++; if (wr_count !== base || gnt !== 4'b0000) begin errors++; $display("FAIL rm_no_write: got writes=%0d gnt=%b want %0d/0000", wr_count, gnt, base); end
  endtask

  task automatic test_burst();
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0011; req_we = 4'b0000; sample();
`ifdef SHA_ARB_BURST_LIMIT_EN
    for (int c = 0; c < 16; c++) begin
      tick(); sample();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL burst_own_%0d: got %b want 0001", c, gnt); end
    end
    tick(); sample();
    checks++; if (gnt !== 4'b0000 || dbg_state !== IDLE || dbg_rr_ptr !== 2'd1) begin errors++; $display("FAIL burst_revoke: got gnt=%b st=%0d ptr=%0d want 0000/IDLE/1", gnt, dbg_state, dbg_rr_ptr); end
    tick(); sample();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL burst_next: got %b want 0010", gnt); end
`else
    for (int c = 0; c < 40; c++) begin
      tick(); sample();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL burst_hold_%0d: got %b want 0001", c, gnt); end
    end
`endif
    tick(); req = 4'b0000; sample();
    tick(); sample();
    checks++; if (dbg_state !== IDLE || gnt !== 4'b0000) begin errors++; $display("FAIL burst_end: got st=%0d gnt=%b want IDLE/0000", dbg_state, gnt); end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_single_read();
    test_all_request();
    test_wrap();
    test_isolation();
    test_reset_mid();
    test_burst();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_mem_arbiter.md
SHA_MEM_ARBITER -- requirements
Module: sha_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of hash-core requesters, range 2..8.
REQ-002 Parameter MAX_BURST, default 16: per-grant cycle limit; used only when SHA_ARB_BURST_LIMIT_EN is defined.
REQ-003 Port clk  in  1  single clock; every register is on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port req  in  NUM_REQ  per-core request, held high for the whole transaction.
REQ-006 Port req_we, req_addr, req_wdata  in  NUM_REQ x 1 / x 16 / x 32  per-core memory command.
REQ-007 Port gnt  out  NUM_REQ  registered one-hot grant.
REQ-008 Port rd_data  out  32  memory read data broadcast to all cores.
REQ-009 Port rd_valid  out  NUM_REQ  one-hot; marks rd_data as belonging to that core.
REQ-010 Port mem_clk  out  1  equal to clk.
REQ-011 Port mem_we  out  1  memory write enable.
REQ-012 Port mem_addr  out  16  memory address.
REQ-013 Port mem_write_data  out  32  memory write data.
REQ-014 Port mem_read_data  in  32  memory read data, valid one cycle after the address is presented.

Function
REQ-015 FSM states: IDLE and OWN.
- IDLE -> OWN when any req is high.
- OWN -> IDLE when req[owner] is low, or on a burst-limit revoke.
REQ-016 IDLE arbitration: the winner is the first requester at or after rr_ptr in round-robin order; gnt[winner] is registered, so it asserts the cycle after the request is seen.
REQ-017 In OWN, mem_we, mem_addr and mem_write_data are combinational pass-throughs of the owner's req_* signals.
REQ-018 In IDLE, mem_we = 0 and mem_addr / mem_write_data hold their last values.
REQ-019 Read return:
- rd_data = mem_read_data.
- rd_valid[owner] is registered high one cycle after any OWN cycle with req_we[owner] = 0 and req[owner] = 1.
- This holds even if the grant dropped in between.
REQ-020 On release (req[owner] low while in OWN), the next cycle has gnt = 0, state = IDLE, rr_ptr = (owner + 1) mod NUM_REQ; the owner index wraps from NUM_REQ-1 to 0.
REQ-021 Handover between owners always costs exactly one IDLE cycle, with mem_we = 0 in that cycle.
REQ-022 A request arriving in the same cycle as a release is arbitrated in that IDLE cycle; gnt asserts the following cycle.
REQ-023 Non-owner req_* inputs are ignored; a request is never lost, only deferred.
REQ-024 gnt is one-hot or all-zero in every cycle.

Reset
REQ-025 While reset is high, at the next edge:
- state = IDLE, gnt = 0, rd_valid = 0, rr_ptr = 0;
- mem_we = 0, mem_addr = 0, mem_write_data = 0;
- burst counter = 0.
REQ-026 A reset asserted mid-transaction aborts the grant and suppresses any pending rd_valid; no memory write is issued in the reset cycle.

Configuration
REQ-027 With SHA_ARB_BURST_LIMIT_EN defined:
- a 6-bit burst counter clears on entry to OWN and increments each OWN cycle;
- when counter = MAX_BURST-1 and any other req is high, the grant is revoked: gnt drops the next cycle, and rr_ptr advances past the owner;
- the revoked core keeps req high and re-arbitrates.
REQ-028 Without SHA_ARB_BURST_LIMIT_EN: no counter is built, MAX_BURST is unused, and an owner holds the grant until it drops req.

Structure
REQ-029 Package sha_mem_pkg holds:
- the state enum arb_state_t (IDLE, OWN);
- constants SHA_ADDR_W = 16, SHA_DATA_W = 32, SHA_MAX_REQ = 8.
REQ-030 Sub-module rr_pick holds the combinational round-robin priority encoder. Inputs: request vector and pointer. Outputs: any and one-hot winner. The block instantiates it once.

Verification
REQ-031 reset, then req = 0001, core 0 reads address 0x0010 for 3 cycles -> gnt = 0001 one cycle later; mem_addr = 0x0010; rd_valid[0] one cycle after each read.
REQ-032 req = 1111 simultaneously, each released after 2 cycles -> grant order 0, 1, 2, 3; one IDLE cycle with mem_we = 0 between grants.
REQ-033 rr_ptr = 3 and req = 1001 -> core 3 granted first, then core 0 (wrap-around).
REQ-034 core 1 writes 0xDEADBEEF to 0x0020 while core 2 drives mem signals -> memory sees only core 1's write; core 2 is granted after core 1 releases.
REQ-035 reset pulsed while core 0 owns with a read outstanding -> next cycle gnt = 0, rd_valid = 0, mem_we = 0, rr_ptr = 0.
REQ-036 SHA_ARB_BURST_LIMIT_EN defined, MAX_BURST = 16, cores 0 and 1 requesting continuously -> core 0 revoked after 16 cycles, core 1 granted after one IDLE cycle; with the macro undefined, core 0 keeps the grant indefinitely.
